// File: rtl/dot_feeder_pkg.sv
// Shared types and sizing helpers for the dot_feeder front end.
package dot_feeder_pkg;

    localparam int DEF_N = 8;
    localparam int DEF_W = 8;

    typedef enum logic [2:0] {
        ST_LOAD_A = 3'd0,
        ST_LOAD_B = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESULT = 3'd4
    } dot_feeder_state_t;

    // Width of an N-term sum of W x W unsigned products.
    function automatic int sum_width(input int n, input int w);
        return 2 * w + $clog2(n);
    endfunction

endpackage

// File: rtl/dot_feeder.sv
// Byte-serial operand loader and result catcher for the 8-lane dot-product engine.
// Optional WAIT watchdog is built when DOT_FEEDER_TIMEOUT_EN is defined.
module dot_feeder
    import dot_feeder_pkg::*;
#(
    parameter int N              = DEF_N,
    parameter int W              = DEF_W,
    parameter int ENGINE_LAT     = 2,
    parameter int TIMEOUT_CYCLES = 15,
    localparam int SUM_W         = sum_width(N, W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    output logic [N*W-1:0]     vec_a,
    output logic [N*W-1:0]     vec_b,
    output logic               compute,
    input  logic               dp_valid,
    input  logic [SUM_W-1:0]   dot_product,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [SUM_W-1:0]   res_data,
    output logic               res_err
);

    localparam int IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam int WCNT_MAX = (TIMEOUT_CYCLES > ENGINE_LAT) ? TIMEOUT_CYCLES : ENGINE_LAT;
    localparam int WCNT_W   = $clog2(WCNT_MAX + 1);

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(N - 1);
    localparam logic [WCNT_W-1:0] CAP_MIN  = WCNT_W'(ENGINE_LAT - 1);
    localparam logic [WCNT_W-1:0] WCNT_SAT = WCNT_W'(WCNT_MAX);

    dot_feeder_state_t   r_state;
    dot_feeder_state_t   w_next_state;
    logic [IDX_W-1:0]    r_idx;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [N*W-1:0]      r_vec_a;
    logic [N*W-1:0]      r_vec_b;
    logic [SUM_W-1:0]    r_res_data;
    logic                w_load_hs;
    logic                w_capture;
    logic                w_timeout;

    assign in_ready  = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B);
    assign w_load_hs = in_valid && in_ready && !flush;

    // The wcnt floor keeps a dp_valid left high by the previous operation from being taken.
    assign w_capture = (r_state == ST_WAIT) && (r_wcnt >= CAP_MIN) && dp_valid && !flush;

`ifdef DOT_FEEDER_TIMEOUT_EN
    localparam logic [WCNT_W-1:0] TO_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);
    logic r_res_err;

    assign w_timeout = (r_state == ST_WAIT) && (r_wcnt >= TO_LAST) && !w_capture && !flush;
    assign res_err   = r_res_err;

    // Error flag accompanies each result: cleared by a capture, set by the watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_err <= 1'b0;
        end else if (w_capture) begin
            r_res_err <= 1'b0;
        end else if (w_timeout) begin
            r_res_err <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign res_err   = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; flush overrides every transition.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_LOAD_A: begin
                if (w_load_hs && (r_idx == IDX_LAST)) begin
                    w_next_state = ST_LOAD_B;
                end else begin
                    w_next_state = ST_LOAD_A;
                end
            end
            ST_LOAD_B: begin
                if (w_load_hs && (r_idx == IDX_LAST)) begin
                    w_next_state = ST_ISSUE;
                end else begin
                    w_next_state = ST_LOAD_B;
                end
            end
            ST_ISSUE: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_capture || w_timeout) begin
                    w_next_state = ST_RESULT;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_RESULT: begin
                if (res_ready) begin
                    w_next_state = ST_LOAD_A;
                end else begin
                    w_next_state = ST_RESULT;
                end
            end
            default: begin
                w_next_state = ST_LOAD_A;
            end
        endcase
        if (flush) begin
            w_next_state = ST_LOAD_A;
        end else begin
            w_next_state = w_next_state;
        end
    end

    // Element index wraps to 0 after the last element of each vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
        end else if (flush) begin
            r_idx <= '0;
        end else if (w_load_hs) begin
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    // Operand registers; only load handshakes write them, so flush leaves them intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec_a <= '0;
            r_vec_b <= '0;
        end else if (w_load_hs) begin
            if (r_state == ST_LOAD_A) begin
                r_vec_a[r_idx*W +: W] <= in_data;
            end else begin
                r_vec_b[r_idx*W +: W] <= in_data;
            end
        end
    end

    // Wait counter saturates so an unbounded WAIT never wraps below the capture floor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_wcnt <= '0;
        end else if ((r_state == ST_WAIT) && (r_wcnt != WCNT_SAT)) begin
            r_wcnt <= r_wcnt + 1'b1;
        end
    end

    // Result capture; a timeout delivers zero data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_data <= '0;
        end else if (w_capture) begin
            r_res_data <= dot_product;
        end else if (w_timeout) begin
            r_res_data <= '0;
        end
    end

    assign vec_a     = r_vec_a;
    assign vec_b     = r_vec_b;
    assign compute   = (r_state == ST_ISSUE);
    assign res_valid = (r_state == ST_RESULT);
    assign res_data  = r_res_data;

endmodule

// File: tb/tb_dot_feeder.sv
// Directed and randomized bench for dot_feeder with a behavioural sticky-valid engine.
module tb_dot_feeder;

    localparam int N          = 8;
    localparam int W          = 8;
    localparam int SUM_W      = 19;
    localparam int ENGINE_LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic [N*W-1:0]    vec_a;
    logic [N*W-1:0]    vec_b;
    logic              compute;
    logic              dp_valid;
    logic [SUM_W-1:0]  dot_product;
    logic              res_valid;
    logic              res_ready;
    logic [SUM_W-1:0]  res_data;
    logic              res_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_compute = 0;
    logic eng_dead = 1'b0;
    bit   gaps     = 1'b0;
    int   eng_cnt;
    logic [SUM_W-1:0] eng_pend;

    logic [7:0] mva [N];
    logic [7:0] mvb [N];
    logic [7:0] ta  [N];
    logic [7:0] tbv [N];

    dot_feeder dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .vec_a(vec_a), .vec_b(vec_b), .compute(compute),
        .dp_valid(dp_valid), .dot_product(dot_product),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_err(res_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (compute) n_compute <= n_compute + 1;
    end

    function automatic logic [SUM_W-1:0] engine_dot(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        logic [SUM_W-1:0] s;
        s = '0;
        for (int i = 0; i < N; i++) s = s + SUM_W'(a[i*W +: W]) * SUM_W'(b[i*W +: W]);
        return s;
    endfunction

    // Engine model: result appears ENGINE_LAT cycles after compute; dp_valid stays high afterwards.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_valid    <= 1'b0;
            eng_cnt     <= 0;
            dot_product <= '0;
        end else if (eng_dead) begin
            dp_valid    <= 1'b0;
            eng_cnt     <= 0;
            dot_product <= '1;
        end else if (compute) begin
            eng_pend <= engine_dot(vec_a, vec_b);
            eng_cnt  <= ENGINE_LAT - 1;
        end else if (eng_cnt == 1) begin
            dot_product <= eng_pend;
            dp_valid    <= 1'b1;
            eng_cnt     <= 0;
        end else if (eng_cnt > 1) begin
            eng_cnt <= eng_cnt - 1;
        end
    end

    function automatic int ref_dot(input logic [7:0] a [N], input logic [7:0] b [N]);
        int s = 0;
        for (int i = 0; i < N; i++) s += int'(a[i]) * int'(b[i]);
        return s;
    endfunction

    function automatic logic [63:0] pack(input logic [7:0] m [N]);
        logic [63:0] p = '0;
        for (int i = 0; i < N; i++) p[i*8 +: 8] = m[i];
        return p;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input bit is_b, input int pos);
        int g = 0;
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && g < 100) begin
            tick();
            g++;
        end
        if (g >= 100) check("send_ready_timeout", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        if (is_b) mvb[pos] = d;
        else      mva[pos] = d;
    endtask

    task automatic load_op(input logic [7:0] a [N], input logic [7:0] b [N]);
        for (int i = 0; i < N; i++) send(a[i], 1'b0, i);
        for (int i = 0; i < N; i++) send(b[i], 1'b1, i);
    endtask

    task automatic wait_result(input string tag);
        int g = 0;
        while (!res_valid && g < 60) begin
            tick();
            g++;
        end
        check({tag, "_res_valid"}, {63'd0, res_valid}, 64'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a [N], input logic [7:0] b [N], input bit timed);
        int t0;
        int nc0;
        int exp;
        exp = ref_dot(a, b);
        nc0 = n_compute;
        t0  = cyc;
        load_op(a, b);
        if (timed) begin
            check({tag, "_compute"}, {63'd0, compute}, 64'd1);
            check({tag, "_compute_cyc"}, 64'(cyc - t0), 64'd16);
        end
        wait_result(tag);
        if (timed) check({tag, "_res_cyc"}, 64'(cyc - t0), 64'd19);
        check({tag, "_data"}, 64'(res_data), 64'(exp));
        check({tag, "_err"}, {63'd0, res_err}, 64'd0);
        check({tag, "_ncompute"}, 64'(n_compute - nc0), 64'd1);
        check({tag, "_vec_a"}, vec_a, pack(mva));
        check({tag, "_vec_b"}, vec_b, pack(mvb));
        tick();
    endtask

    initial begin
        int t_issue;
        int nc0;
        int seen;
        int exp;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hAA; res_ready = 1'b1;
        for (int i = 0; i < N; i++) begin mva[i] = 8'd0; mvb[i] = 8'd0; end
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_in_ready", {63'd0, in_ready}, 64'd1);
            check("rst_compute", {63'd0, compute}, 64'd0);
            check("rst_res_valid", {63'd0, res_valid}, 64'd0);
            check("rst_res_data", 64'(res_data), 64'd0);
            check("rst_res_err", {63'd0, res_err}, 64'd0);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0;
        check("rst_vec_a", vec_a, 64'd0);
        check("rst_vec_b", vec_b, 64'd0);

        // A=1..8, B=all 1, latency and result.
        for (int i = 0; i < N; i++) begin ta[i] = 8'(i + 1); tbv[i] = 8'd1; end
        run_op("t1", ta, tbv, 1'b1);

        // Maximum operands.
        for (int i = 0; i < N; i++) begin ta[i] = 8'd255; tbv[i] = 8'd255; end
        run_op("tmax", ta, tbv, 1'b0);

        // Back-to-back: stale dp_valid from the first must not be captured by the second.
        for (int i = 0; i < N; i++) begin ta[i] = 8'd2; tbv[i] = 8'd3; end
        run_op("b2b1", ta, tbv, 1'b0);
        for (int i = 0; i < N; i++) begin ta[i] = 8'd0; tbv[i] = 8'd0; end
        run_op("b2b2", ta, tbv, 1'b0);

        // Random operands with random input gaps.
        gaps = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < N; i++) begin
                ta[i]  = 8'($urandom_range(0, 255));
                tbv[i] = 8'($urandom_range(0, 255));
            end
            run_op("rand", ta, tbv, 1'b0);
        end
        gaps = 1'b0;

        // Downstream backpressure.
        for (int i = 0; i < N; i++) begin ta[i] = 8'(3 * i + 1); tbv[i] = 8'(200 - i); end
        exp = ref_dot(ta, tbv);
        res_ready = 1'b0;
        load_op(ta, tbv);
        wait_result("hold");
        for (int i = 0; i < 5; i++) begin
            check("hold_res_valid", {63'd0, res_valid}, 64'd1);
            check("hold_res_data", 64'(res_data), 64'(exp));
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        check("hold_release_valid", {63'd0, res_valid}, 64'd0);
        check("hold_release_ready", {63'd0, in_ready}, 64'd1);

        // Flush on the 4th B handshake.
        nc0 = n_compute;
        for (int i = 0; i < N; i++) send(8'(i + 10), 1'b0, i);
        for (int i = 0; i < 3; i++) send(8'd5, 1'b1, i);
        in_valid = 1'b1; in_data = 8'd99; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("flush_ncompute", 64'(n_compute - nc0), 64'd0);
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        check("flush_vec_a", vec_a, pack(mva));
        check("flush_vec_b", vec_b, pack(mvb));
        for (int i = 0; i < N; i++) begin ta[i] = 8'd2; tbv[i] = 8'd2; end
        run_op("flush_reload", ta, tbv, 1'b0);

        // Engine never answers.
        eng_dead = 1'b1;
        tick();
        for (int i = 0; i < N; i++) begin ta[i] = 8'd1; tbv[i] = 8'd1; end
        load_op(ta, tbv);
        t_issue = cyc;
`ifdef DOT_FEEDER_TIMEOUT_EN
        wait_result("tmo");
        check("tmo_cyc", 64'(cyc - t_issue), 64'd16);
        check("tmo_err", {63'd0, res_err}, 64'd1);
        check("tmo_data", 64'(res_data), 64'd0);
        tick();
        check("tmo_release", {63'd0, in_ready}, 64'd1);
`else
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (res_valid || in_ready) seen++;
            tick();
        end
        check("nowdt_stuck", 64'(seen), 64'd0);
        check("nowdt_err", {63'd0, res_err}, 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("nowdt_flush_ready", {63'd0, in_ready}, 64'd1);
`endif
        eng_dead = 1'b0;
        tick();

        // Reset mid-load abandons everything immediately.
        for (int i = 0; i < 3; i++) send(8'd77, 1'b0, i);
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("mid_rst_vec_a", vec_a, 64'd0);
        check("mid_rst_vec_b", vec_b, 64'd0);
        check("mid_rst_res_data", 64'(res_data), 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin mva[i] = 8'd0; mvb[i] = 8'd0; end
        tick();
        for (int i = 0; i < N; i++) begin ta[i] = 8'(i * 7); tbv[i] = 8'(i + 4); end
        run_op("post_rst", ta, tbv, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
